// File: rtl/gbuf_stream_reader.sv
// Strided global-buffer reader that streams words out through a small FIFO; optional GBUF_READER_PERF_EN adds stall_cycles.
// Latency: 3 cycles from accepted start to first m_valid, then one word per cycle with m_ready high.
// Backpressure: reads are only issued while in-flight + buffered words fit in the FIFO, so m_ready low throttles issue.
module gbuf_stream_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int LEN_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  input  logic [ADDR_WIDTH-1:0] stride,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] buf_addr,
  output logic                  buf_ce,
  output logic                  buf_we,
  output logic [DATA_WIDTH-1:0] buf_wdata,
  input  logic [DATA_WIDTH-1:0] buf_rdata,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready
`ifdef GBUF_READER_PERF_EN
  ,
  output logic [31:0]           stall_cycles
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] stride_q;
  logic [LEN_WIDTH-1:0]  issue_left;
  logic [LEN_WIDTH-1:0]  out_left;
  logic                  rd_pend;
  logic                  done_q;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  accept;
  logic                  push;
  logic                  pop;
  logic                  last_pop;

  assign accept    = (state == IDLE) && start;
  assign push      = rd_pend;
  assign m_valid   = (count != '0);
  assign pop       = m_valid && m_ready;
  assign m_last    = m_valid && (out_left == LEN_WIDTH'(1));
  assign last_pop  = pop && m_last;
  assign m_data    = m_valid ? mem[rd_ptr] : '0;
  assign busy      = (state != IDLE);
  assign done      = done_q;
  assign buf_addr  = addr_q;
  assign buf_we    = 1'b0;
  assign buf_wdata = '0;

  always_comb begin
    state_nxt = state;
    buf_ce    = 1'b0;
    case (state)
      IDLE: begin
        if (start && (length != '0)) state_nxt = ISSUE;
      end
      ISSUE: begin
        // Budget counts the read whose data lands next cycle, so a full FIFO never gets one more push.
        if ((CNT_W'(rd_pend) + count) < DEPTH_C) buf_ce = 1'b1;
        if (buf_ce && (issue_left == LEN_WIDTH'(1))) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (last_pop) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      stride_q   <= '0;
      issue_left <= '0;
      out_left   <= '0;
      rd_pend    <= 1'b0;
      done_q     <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      state   <= state_nxt;
      rd_pend <= buf_ce;
      done_q  <= last_pop || (accept && (length == '0));
      if (accept) begin
        addr_q     <= base_addr;
        stride_q   <= stride;
        issue_left <= length;
        out_left   <= length;
      end else begin
        if (buf_ce) begin
          addr_q     <= addr_q + stride_q;
          issue_left <= issue_left - LEN_WIDTH'(1);
        end
        if (pop) out_left <= out_left - LEN_WIDTH'(1);
      end
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= buf_rdata;
  end

`ifdef GBUF_READER_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (accept) begin
      stall_cycles <= '0;
    end else if (busy && m_valid && !m_ready && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gbuf_stream_reader.sv
// Bench for gbuf_stream_reader: table of transfers checked through an address/data scoreboard,
// plus hand-written zero-length and mid-transfer reset sequences.
module tb_gbuf_stream_reader;
  localparam int DW    = 32;
  localparam int AW    = 16;
  localparam int LW    = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] length;
  logic [AW-1:0] stride;
  logic          busy;
  logic          done;
  logic [AW-1:0] buf_addr;
  logic          buf_ce;
  logic          buf_we;
  logic [DW-1:0] buf_wdata;
  logic [DW-1:0] buf_rdata;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          m_ready;
`ifdef GBUF_READER_PERF_EN
  logic [31:0]   stall_cycles;
`endif

  always #5 clk = ~clk;

  gbuf_stream_reader #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .stride(stride), .busy(busy), .done(done), .buf_addr(buf_addr), .buf_ce(buf_ce),
    .buf_we(buf_we), .buf_wdata(buf_wdata), .buf_rdata(buf_rdata), .m_valid(m_valid),
    .m_data(m_data), .m_last(m_last), .m_ready(m_ready)
`ifdef GBUF_READER_PERF_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  typedef struct {
    logic [AW-1:0] base;
    logic [LW-1:0] len;
    logic [AW-1:0] stride;
    int            stall_n;
    bit            inject;
    int            exp_first;
    int            exp_done;
  } vec_t;

  vec_t vecs[7];
  vec_t post_rst;

  int n_checks = 0;
  int n_fail   = 0;

  logic [AW-1:0] exp_addr[$];
  logic [DW:0]   exp_dat[$];

  // monitor-owned
  int          issued   = 0;
  int          popped   = 0;
  int          out_now  = 0;
  int          done_cnt = 0;
  bit          prev_stall = 1'b0;
  logic [DW:0] prev_word;
  // main-owned
  bit          mon_en = 1'b0;

  function automatic void check(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    end
  endfunction

  function automatic logic [DW-1:0] mdata(input logic [AW-1:0] a);
    return {a ^ 16'h5A5A, a};
  endfunction

  // Global-buffer model: one-cycle read latency, garbage when not read.
  always @(posedge clk) buf_rdata <= buf_ce ? mdata(buf_addr) : 32'hDEAD_BEEF;

  always @(negedge clk) begin
    logic [AW-1:0] ea;
    logic [DW:0]   ed;
    if (done) done_cnt++;
    if (mon_en && !rst) begin
      if (buf_ce) begin
        issued++;
        if (exp_addr.size() == 0) check(1'b0, "unexpected_read", 64'(buf_addr), 64'(0));
        else begin
          ea = exp_addr.pop_front();
          check(buf_addr == ea, "read_addr", 64'(buf_addr), 64'(ea));
        end
      end
      out_now = issued - popped;
      if (prev_stall)
        check(m_valid && ({m_last, m_data} == prev_word), "stall_stable",
              64'({m_valid, m_last, m_data}), 64'({1'b1, prev_word}));
      if (m_valid && m_ready) begin
        popped++;
        if (exp_dat.size() == 0) check(1'b0, "unexpected_word", 64'({m_last, m_data}), 64'(0));
        else begin
          ed = exp_dat.pop_front();
          check({m_last, m_data} == ed, "word_last_data", 64'({m_last, m_data}), 64'(ed));
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_word  = {m_last, m_data};
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic run_xfer(input vec_t v);
    logic [AW-1:0] a;
    int lat, fv, stalls_left, iss0, pop0, max_out;
    a = v.base;
    for (int n = 0; n < int'(v.len); n++) begin
      exp_addr.push_back(a);
      exp_dat.push_back({(n == int'(v.len) - 1), mdata(a)});
      a = a + v.stride;
    end
    iss0 = issued; pop0 = popped; max_out = 0;
    stalls_left = v.stall_n;
    m_ready   = (v.stall_n == 0);
    start     = 1'b1;
    base_addr = v.base; length = v.len; stride = v.stride;
    lat = -1; fv = -1;
    for (int i = 1; i <= 400 && lat < 0; i++) begin
      @(posedge clk); #1;
      start = v.inject && (i == 2);
      if (start) begin
        base_addr = 16'h7777; length = 16'd2; stride = 16'd1;
      end
      if (out_now > max_out) max_out = out_now;
      if (i == 1) check(busy == 1'b1, "busy_after_start", 64'(busy), 64'(1));
      if (m_valid && fv < 0) fv = i;
      if (!m_ready && m_valid) begin
        if (stalls_left == 0) m_ready = 1'b1;
        else stalls_left--;
      end
      if (done) begin
        lat = i;
        check(busy == 1'b0, "busy_at_done", 64'(busy), 64'(0));
      end
    end
    check(lat >= 0, "done_timeout", 64'(lat), 64'(v.exp_done));
    if (v.exp_done >= 0) check(lat == v.exp_done, "done_latency", 64'(lat), 64'(v.exp_done));
    check(fv == v.exp_first, "first_valid_latency", 64'(fv), 64'(v.exp_first));
    check(issued - iss0 == int'(v.len), "reads_issued", 64'(issued - iss0), 64'(v.len));
    check(popped - pop0 == int'(v.len), "words_delivered", 64'(popped - pop0), 64'(v.len));
    check(exp_addr.size() == 0 && exp_dat.size() == 0, "scoreboard_empty",
          64'(exp_addr.size() + exp_dat.size()), 64'(0));
    check(max_out <= DEPTH, "max_outstanding", 64'(max_out), 64'(DEPTH));
`ifdef GBUF_READER_PERF_EN
    check(stall_cycles == 32'(v.stall_n), "stall_cycles", 64'(stall_cycles), 64'(v.stall_n));
`endif
    exp_addr.delete();
    exp_dat.delete();
  endtask

  initial begin
    int d0, iss0, k;
    //           base      len     stride  stall inj first done
    vecs[0] = '{16'h0010, 16'd4,  16'd1,   0,  1'b0, 3,  7};
    vecs[1] = '{16'hFFFE, 16'd3,  16'd1,   0,  1'b0, 3,  6};
    vecs[2] = '{16'h0100, 16'd10, 16'd1,   8,  1'b0, 3, -1};
    vecs[3] = '{16'h8000, 16'd6,  16'd3,   0,  1'b1, 3,  9};
    vecs[4] = '{16'hFFF0, 16'd5,  16'd7,   0,  1'b0, 3,  8};
    vecs[5] = '{16'h0042, 16'd1,  16'd5,   0,  1'b0, 3,  4};
    vecs[6] = '{16'h0200, 16'd5,  16'd2,   6,  1'b0, 3, -1};
    post_rst = '{16'h0400, 16'd4, 16'd4,   0,  1'b0, 3,  7};

    rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; stride = '0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check(busy == 1'b0,    "rst_busy",     64'(busy),     64'(0));
    check(done == 1'b0,    "rst_done",     64'(done),     64'(0));
    check(buf_ce == 1'b0,  "rst_buf_ce",   64'(buf_ce),   64'(0));
    check(m_valid == 1'b0, "rst_m_valid",  64'(m_valid),  64'(0));
    check(m_last == 1'b0,  "rst_m_last",   64'(m_last),   64'(0));
    check(buf_addr == '0,  "rst_buf_addr", 64'(buf_addr), 64'(0));
    check(m_data == '0,    "rst_m_data",   64'(m_data),   64'(0));
    check(buf_we == 1'b0 && buf_wdata == '0, "write_tied_off", 64'({buf_we, buf_wdata}), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check(busy == 1'b0 && m_valid == 1'b0, "post_rst_idle", 64'({busy, m_valid}), 64'(0));
    mon_en = 1'b1;

    // Back-to-back: each transfer starts in the previous one's done cycle.
    for (int i = 0; i < 7; i++) run_xfer(vecs[i]);

    // Zero-length start: no reads, done next cycle, busy stays low.
    iss0 = issued;
    start = 1'b1; base_addr = 16'h0055; length = '0; stride = 16'd1;
    @(posedge clk); #1;
    start = 1'b0;
    check(done == 1'b1, "zero_len_done", 64'(done), 64'(1));
    check(busy == 1'b0, "zero_len_busy", 64'(busy), 64'(0));
    @(posedge clk); #1;
    check(done == 1'b0 && busy == 1'b0, "zero_len_after", 64'({done, busy}), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    check(issued == iss0, "zero_len_no_reads", 64'(issued - iss0), 64'(0));

    // Reset with two words buffered aborts the transfer silently.
    mon_en = 1'b0;
    m_ready = 1'b0;
    start = 1'b1; base_addr = 16'h0300; length = 16'd8; stride = 16'd1;
    k = 0;
    for (int i = 1; i <= 20 && k == 0; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (m_valid) k = i;
    end
    check(k == 3, "abort_first_valid", 64'(k), 64'(3));
    @(posedge clk); #1;
    rst = 1'b1;
    d0 = done_cnt;
    @(posedge clk); #1;
    rst = 1'b0;
    check(m_valid == 1'b0, "abort_m_valid", 64'(m_valid), 64'(0));
    check(busy == 1'b0,    "abort_busy",    64'(busy),    64'(0));
    check(m_data == '0,    "abort_m_data",  64'(m_data),  64'(0));
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check(m_valid == 1'b0 && buf_ce == 1'b0, "abort_discard", 64'({m_valid, buf_ce}), 64'(0));
    end
    check(done_cnt == d0, "abort_no_done", 64'(done_cnt - d0), 64'(0));
    mon_en = 1'b1;
    run_xfer(post_rst);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gbuf_stream_reader.md
GBUF_STREAM_READER -- requirements
Module: gbuf_stream_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of each global-buffer word and of each stream word.
REQ-002 Parameter ADDR_WIDTH, default 16, global-buffer word-address width.
REQ-003 Parameter LEN_WIDTH, default 16, transfer-length width in words.
REQ-004 Parameter FIFO_DEPTH, default 4, output FIFO entries; power of two, >= 2.
REQ-005 clk  in  1  sole clock; all logic SHALL operate on its rising edge.
REQ-006 rst  in  1  reset; synchronous, active-high.
REQ-007 start  in  1  request a transfer; sampled only in IDLE.
REQ-008 base_addr  in  ADDR_WIDTH  first word address; captured on accepted start.
REQ-009 length  in  LEN_WIDTH  number of words; captured on accepted start.
REQ-010 stride  in  ADDR_WIDTH  address increment between words; captured on accepted start.
REQ-011 busy  out  1  high from the cycle after an accepted start until done.
REQ-012 done  out  1  one-cycle completion pulse.
REQ-013 buf_addr  out  ADDR_WIDTH  global-buffer address.
REQ-014 buf_ce  out  1  global-buffer chip enable, one read per asserted cycle.
REQ-015 buf_we  out  1  global-buffer write enable; constant 0.
REQ-016 buf_wdata  out  DATA_WIDTH  global-buffer write data; constant 0.
REQ-017 buf_rdata  in  DATA_WIDTH  global-buffer read data, valid one cycle after buf_ce.
REQ-018 m_valid  out  1  output stream word valid.
REQ-019 m_data  out  DATA_WIDTH  output stream word.
REQ-020 m_last  out  1  high with the final word of a transfer.
REQ-021 m_ready  in  1  downstream accepts the word when m_valid and m_ready are both high.

Function
REQ-022 The FSM SHALL have three states: IDLE, ISSUE and DRAIN.
- IDLE -> ISSUE on start with length != 0.
- ISSUE -> DRAIN in the cycle the last read is issued.
- DRAIN -> IDLE on handshake of the m_last word.
REQ-023 A start with length == 0 SHALL produce no reads, pulse done on the next cycle, and keep the block in IDLE with busy low.
REQ-024 A start asserted while not in IDLE SHALL be ignored, with no effect on the current transfer.
REQ-025 In ISSUE, buf_ce SHALL be asserted only when (reads in flight + FIFO occupancy) < FIFO_DEPTH, so the FIFO never overflows.
REQ-026 Read n SHALL use address base_addr + n*stride modulo 2^ADDR_WIDTH; wrap-around is silent.
REQ-027 buf_rdata SHALL be written into the FIFO exactly one cycle after each buf_ce, independent of m_ready.
REQ-028 Words SHALL leave the FIFO in issue order; m_data and m_last SHALL be stable while m_valid is high and m_ready is low.
REQ-029 m_last SHALL be high only on word length-1.
REQ-030 done SHALL pulse in the cycle after the m_last handshake, coincident with busy falling; a new start is accepted in that same cycle.
REQ-031 With m_ready held high, the block SHALL sustain one read and one output word per cycle; start-to-first-m_valid latency is 3 cycles (start accept, read issue, FIFO write).
REQ-032 A simultaneous FIFO write and read SHALL leave occupancy unchanged.

Reset
REQ-033 rst SHALL force the FSM to IDLE and clear the FIFO pointers, the in-flight tracking, the counters and the captured registers.
REQ-034 During and after reset, busy, done, buf_ce, m_valid and m_last SHALL be 0, and buf_addr and m_data SHALL be 0.
REQ-035 rst asserted mid-transfer SHALL abort the transfer without a done pulse; read data returning in the cycle after reset release SHALL be discarded.

Configuration
REQ-036 When GBUF_READER_PERF_EN is defined, the block SHALL add output stall_cycles [31:0].
- It SHALL be cleared on an accepted start.
- It SHALL increment, saturating, in each cycle where busy, m_valid and !m_ready all hold.
- It SHALL hold its value in IDLE, and be 0 after reset.
REQ-037 When GBUF_READER_PERF_EN is not defined, the port and the counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-038 base=0x0010, len=4, stride=1, m_ready=1 -> reads at 0x10..0x13 on consecutive cycles; 4 words in order; m_last on the 4th; done 1 cycle later.
REQ-039 base=0xFFFE, len=3, stride=1 -> addresses 0xFFFE, 0xFFFF, 0x0000.
REQ-040 len=10, m_ready low for 8 cycles after the first m_valid -> at most FIFO_DEPTH reads outstanding plus buffered; no data lost; m_data stable while stalled; 10 words delivered.
REQ-041 len=0 -> no buf_ce, done pulses next cycle, busy stays 0; a start during busy -> ignored.
REQ-042 rst pulsed mid-transfer with 2 words buffered -> m_valid=0 next cycle, no done pulse, the next transfer is correct.
REQ-043 With GBUF_READER_PERF_EN defined: len=5, m_ready low for 6 cycles while m_valid=1 -> stall_cycles=6 at done.
